// File: rtl/mips_hazard_if.sv
// Hazard-unit bundle: pipeline-stage observations in, stall/flush/forward controls out.
interface mips_hazard_if;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E;
  logic [4:0] WriteReg_E, WriteReg_M, WriteReg_W;
  logic       RegWrite_E, RegWrite_M, RegWrite_W;
  logic       MemtoReg_E, MemtoReg_M;
  logic       Branch_D, BranchTaken_D, J_D, Jr_D;
  logic       HiLoAccess_D, MulDivStart_E, MulDivOp_E;
  logic       Stall_F, EN_FD, CLR_FD, EN_DE, CLR_DE;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       ForwardA_D, ForwardB_D;
  logic       MulDivBusy, MulDivDone;

  modport master (
    output Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M,
           Branch_D, BranchTaken_D, J_D, Jr_D, HiLoAccess_D, MulDivStart_E, MulDivOp_E,
    input  Stall_F, EN_FD, CLR_FD, EN_DE, CLR_DE, ForwardA_E, ForwardB_E,
           ForwardA_D, ForwardB_D, MulDivBusy, MulDivDone
  );

  modport slave (
    input  Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M,
           Branch_D, BranchTaken_D, J_D, Jr_D, HiLoAccess_D, MulDivStart_E, MulDivOp_E,
    output Stall_F, EN_FD, CLR_FD, EN_DE, CLR_DE, ForwardA_E, ForwardB_E,
           ForwardA_D, ForwardB_D, MulDivBusy, MulDivDone
  );
endinterface

// File: rtl/mips_hazard_unit.sv
// 5-stage MIPS hazard/forwarding controller with a mult/div busy tracker that
// holds HI/LO accessors in Decode until the result is ready.
module mips_hazard_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  mips_hazard_if.slave hz
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lwstall, branchstall, mdstall, stall, flush;

  function automatic logic match(input logic we, input logic [4:0] wr, input logic [4:0] r);
    return we && (r != 5'd0) && (wr == r);
  endfunction

  // Branch/jr operands are compared in Decode, so a result still in Execute,
  // or a load still in Memory, cannot be forwarded in time.
  function automatic logic hit(input logic [4:0] r);
    return match(hz.RegWrite_E, hz.WriteReg_E, r) ||
           (hz.MemtoReg_M && (hz.WriteReg_M == r) && (r != 5'd0));
  endfunction

  always_comb begin
    hz.ForwardA_E = match(hz.RegWrite_M, hz.WriteReg_M, hz.Rs_E) ? 2'b10 :
                    match(hz.RegWrite_W, hz.WriteReg_W, hz.Rs_E) ? 2'b01 : 2'b00;
    hz.ForwardB_E = match(hz.RegWrite_M, hz.WriteReg_M, hz.Rt_E) ? 2'b10 :
                    match(hz.RegWrite_W, hz.WriteReg_W, hz.Rt_E) ? 2'b01 : 2'b00;
    hz.ForwardA_D = match(hz.RegWrite_M, hz.WriteReg_M, hz.Rs_D);
    hz.ForwardB_D = match(hz.RegWrite_M, hz.WriteReg_M, hz.Rt_D);
  end

  assign lwstall     = hz.MemtoReg_E && (hz.Rt_E != 5'd0) &&
                       ((hz.Rt_E == hz.Rs_D) || (hz.Rt_E == hz.Rt_D));
  assign branchstall = (hz.Branch_D && (hit(hz.Rs_D) || hit(hz.Rt_D))) ||
                       (hz.Jr_D && hit(hz.Rs_D));
  assign mdstall     = hz.HiLoAccess_D && ((state == BUSY) || hz.MulDivStart_E);
  assign stall       = lwstall | branchstall | mdstall;
  // A stalled redirect is retried once the stall clears.
  assign flush       = (hz.BranchTaken_D | hz.J_D | hz.Jr_D) & ~stall;

  assign hz.Stall_F = stall;
  assign hz.EN_FD   = ~stall & ~flush;
  assign hz.CLR_FD  = flush;
  assign hz.EN_DE   = ~stall;
  assign hz.CLR_DE  = stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (hz.MulDivStart_E) begin
        cnt_nxt   = hz.MulDivOp_E ? DIV_LAST : MULT_LAST;
        state_nxt = BUSY;
      end
      BUSY: if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign hz.MulDivBusy = (state == BUSY);
  assign hz.MulDivDone = (state == BUSY) && (cnt == '0);
endmodule

// File: tb/tb_mips_hazard_unit.sv
// Directed bench for mips_hazard_unit: expected outputs queued per cycle,
// popped and compared by an independent monitor mid-cycle.
module tb_mips_hazard_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_hazard_if hz ();
  mips_hazard_unit #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz)
  );

  typedef struct {
    string      name;
    logic [12:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   inv_on = 1'b0;

  logic [12:0] got;
  assign got = {hz.Stall_F, hz.EN_FD, hz.CLR_FD, hz.EN_DE, hz.CLR_DE,
                hz.ForwardA_E, hz.ForwardB_E, hz.ForwardA_D, hz.ForwardB_D,
                hz.MulDivBusy, hz.MulDivDone};

  function automatic logic [12:0] P(input logic st, en_fd, clr_fd, en_de, clr_de,
                                    input logic [1:0] fa, fb,
                                    input logic fad, fbd, busy, done);
    return {st, en_fd, clr_fd, en_de, clr_de, fa, fb, fad, fbd, busy, done};
  endfunction

  localparam logic [12:0] RUN   = 13'b0_1_0_1_0_00_00_0_0_0_0;
  localparam logic [12:0] STALL = 13'b1_0_0_0_1_00_00_0_0_0_0;
  localparam logic [12:0] FLUSH = 13'b0_0_1_1_0_00_00_0_0_0_0;

  // Monitor: one queued expectation per cycle, plus EN/CLR exclusivity during sweeps.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      tests++;
      if (got !== e.exp) begin
        fails++;
        $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
      end
    end
    if (inv_on) begin
      tests++;
      if ((hz.EN_FD && hz.CLR_FD) || (hz.EN_DE && hz.CLR_DE)) begin
        fails++;
        $display("FAIL en_clr_excl: got EN_FD/CLR_FD=%b%b EN_DE/CLR_DE=%b%b expected no 11",
                 hz.EN_FD, hz.CLR_FD, hz.EN_DE, hz.CLR_DE);
      end
    end
  end

  task automatic clr_in();
    hz.Rs_D = 0; hz.Rt_D = 0; hz.Rs_E = 0; hz.Rt_E = 0;
    hz.WriteReg_E = 0; hz.WriteReg_M = 0; hz.WriteReg_W = 0;
    hz.RegWrite_E = 0; hz.RegWrite_M = 0; hz.RegWrite_W = 0;
    hz.MemtoReg_E = 0; hz.MemtoReg_M = 0;
    hz.Branch_D = 0; hz.BranchTaken_D = 0; hz.J_D = 0; hz.Jr_D = 0;
    hz.HiLoAccess_D = 0; hz.MulDivStart_E = 0; hz.MulDivOp_E = 0;
  endtask

  // Queue this cycle's expectation, then advance to the next cycle with inputs cleared.
  task automatic step(input string nm, input logic [12:0] e);
    exp_t x;
    x.name = nm; x.exp = e;
    q.push_back(x);
    @(posedge clk); #1;
    clr_in();
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    @(posedge clk); #1;
    step("reset", RUN);
    rst_n = 1'b1;

    // Execute/Decode forwarding
    hz.RegWrite_M = 1; hz.WriteReg_M = 5; hz.RegWrite_W = 1; hz.WriteReg_W = 5; hz.Rs_E = 5;
    step("fwdA_mem_wins", P(0,1,0,1,0,2'b10,2'b00,0,0,0,0));
    hz.RegWrite_W = 1; hz.WriteReg_W = 5; hz.WriteReg_M = 5; hz.Rs_E = 5;
    step("fwdA_wb", P(0,1,0,1,0,2'b01,2'b00,0,0,0,0));
    hz.RegWrite_M = 1; hz.WriteReg_M = 5; hz.RegWrite_W = 1; hz.WriteReg_W = 5;
    step("fwdA_r0", RUN);
    hz.RegWrite_M = 1; hz.WriteReg_M = 7; hz.Rt_E = 7; hz.Rs_D = 7; hz.Rt_D = 7;
    step("fwdB_and_D", P(0,1,0,1,0,2'b00,2'b10,1,1,0,0));

    // Load-use
    hz.MemtoReg_E = 1; hz.Rt_E = 8; hz.Rs_D = 8;
    step("lwstall", STALL);
    step("lwstall_release", RUN);
    hz.MemtoReg_E = 1;
    step("lw_r0_nostall", RUN);

    // Branch / jump
    hz.Branch_D = 1; hz.BranchTaken_D = 1; hz.Rs_D = 3; hz.RegWrite_E = 1; hz.WriteReg_E = 3;
    step("br_stall_noflush", STALL);
    hz.Branch_D = 1; hz.BranchTaken_D = 1; hz.Rs_D = 3;
    step("br_taken_flush", FLUSH);
    hz.Branch_D = 1; hz.Rt_D = 9; hz.MemtoReg_M = 1; hz.RegWrite_M = 1; hz.WriteReg_M = 9;
    step("br_load_in_mem", P(1,0,0,0,1,2'b00,2'b00,0,1,0,0));
    hz.Jr_D = 1; hz.Rs_D = 4; hz.RegWrite_E = 1; hz.WriteReg_E = 4;
    step("jr_stall", STALL);
    hz.Jr_D = 1; hz.Rs_D = 4;
    step("jr_flush", FLUSH);
    hz.J_D = 1;
    step("j_flush", FLUSH);
    hz.Jr_D = 1; hz.Rs_D = 1; hz.Rt_D = 4; hz.RegWrite_E = 1; hz.WriteReg_E = 4;
    step("jr_ignores_rt", FLUSH);
    hz.Branch_D = 1; hz.RegWrite_E = 1;
    step("br_r0_nostall", RUN);

    // mult: start in cycle 0, Busy 1..4, Done 4, mflo proceeds in cycle 5
    hz.MulDivStart_E = 1; hz.HiLoAccess_D = 1;
    step("mult_c0", STALL);
    hz.HiLoAccess_D = 1;
    step("mult_c1", P(1,0,0,0,1,2'b00,2'b00,0,0,1,0));
    hz.HiLoAccess_D = 1; hz.MulDivStart_E = 1; hz.MulDivOp_E = 1;
    hz.MemtoReg_E = 1; hz.Rt_E = 8; hz.Rs_D = 8;
    step("mult_c2_lw_restart_ign", P(1,0,0,0,1,2'b00,2'b00,0,0,1,0));
    hz.HiLoAccess_D = 1;
    step("mult_c3", P(1,0,0,0,1,2'b00,2'b00,0,0,1,0));
    hz.HiLoAccess_D = 1;
    step("mult_c4_done", P(1,0,0,0,1,2'b00,2'b00,0,0,1,1));
    hz.HiLoAccess_D = 1;
    step("mult_c5_release", RUN);

    // div aborted by reset in cycle 10
    hz.MulDivStart_E = 1; hz.MulDivOp_E = 1;
    step("div_c0", RUN);
    for (int c = 1; c < 10; c++) step("div_busy", P(0,1,0,1,0,2'b00,2'b00,0,0,1,0));
    rst_n = 1'b0; hz.HiLoAccess_D = 1;
    step("div_c10_rst", P(1,0,0,0,1,2'b00,2'b00,0,0,1,0));
    rst_n = 1'b1; hz.HiLoAccess_D = 1;
    step("div_c11_aborted", RUN);

    // full-length div
    hz.MulDivStart_E = 1; hz.MulDivOp_E = 1;
    step("divfull_c0", RUN);
    for (int c = 1; c < 32; c++) step("divfull_busy", P(0,1,0,1,0,2'b00,2'b00,0,0,1,0));
    step("divfull_c32_done", P(0,1,0,1,0,2'b00,2'b00,0,0,1,1));
    step("divfull_c33_idle", RUN);

    // Random sweep for EN/CLR exclusivity
    inv_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      hz.Rs_D = 5'($urandom_range(0, 3)); hz.Rt_D = 5'($urandom_range(0, 3));
      hz.Rs_E = 5'($urandom_range(0, 3)); hz.Rt_E = 5'($urandom_range(0, 3));
      hz.WriteReg_E = 5'($urandom_range(0, 3)); hz.WriteReg_M = 5'($urandom_range(0, 3));
      hz.WriteReg_W = 5'($urandom_range(0, 3));
      {hz.RegWrite_E, hz.RegWrite_M, hz.RegWrite_W, hz.MemtoReg_E, hz.MemtoReg_M,
       hz.Branch_D, hz.BranchTaken_D, hz.J_D, hz.Jr_D, hz.HiLoAccess_D,
       hz.MulDivStart_E, hz.MulDivOp_E} = 12'($urandom);
      @(posedge clk); #1;
    end
    inv_on = 1'b0;
    clr_in();

    for (int w = 0; w < 4 && q.size() != 0; w++) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_hazard_unit.md
Name: mips_hazard_unit

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Generates enable/clear controls for the Fetch/Decode and Decode/Execute pipeline registers, and the PC hold signal.
- Generates forwarding selects for the Execute-stage ALU operands and the Decode-stage branch comparator.
- Tracks the multi-cycle mult/div unit with a small FSM and stalls HI/LO accessors until the result is ready.

Parameters:
- MULT_CYCLES, 4: Execute cycles the mult/div unit is busy for mult/multu (>=1).
- DIV_CYCLES, 32: Execute cycles the mult/div unit is busy for div/divu (>=1).
- CNT_W, 6: busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- Rs_D / Rt_D, in, 5 each: Decode source register numbers.
- Rs_E / Rt_E, in, 5 each: Execute source register numbers.
- WriteReg_E / WriteReg_M / WriteReg_W, in, 5 each: destination register per stage.
- RegWrite_E / RegWrite_M / RegWrite_W, in, 1 each: register write enable per stage.
- MemtoReg_E / MemtoReg_M, in, 1 each: load in Execute / Memory.
- Branch_D, in, 1: conditional branch in Decode (compares Rs and Rt).
- BranchTaken_D, in, 1: branch resolved taken in Decode.
- J_D / Jr_D, in, 1 each: jump / jump-register in Decode (Jr reads Rs only).
- HiLoAccess_D, in, 1: Decode instruction is mfhi/mflo/mthi/mtlo/mult/div.
- MulDivStart_E, in, 1: mult/div issuing in Execute this cycle.
- MulDivOp_E, in, 1: 0 = mult, 1 = div; valid only with MulDivStart_E.
- Stall_F, out, 1: hold PC.
- EN_FD / CLR_FD, out, 1 each: Fetch/Decode register enable / clear.
- EN_DE / CLR_DE, out, 1 each: Decode/Execute register enable / clear.
- ForwardA_E / ForwardB_E, out, 2 each: Execute operand select. 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- ForwardA_D / ForwardB_D, out, 1 each: Decode comparator takes the Memory ALU result.
- MulDivBusy, out, 1: mult/div unit in progress.
- MulDivDone, out, 1: one-cycle pulse on the last busy cycle.

Behaviour:
- Pipeline registers load when EN=1, clear when EN=0 and CLR=1, and hold otherwise. EN has priority over CLR, so this block never drives EN=1 and CLR=1 together on one register.
- matchX(r) = RegWrite_X && r != 0 && WriteReg_X == r.
- ForwardA_E = 10 if matchM(Rs_E), else 01 if matchW(Rs_E), else 00. ForwardB_E is the same using Rt_E. The Memory stage wins on a double match.
- ForwardA_D = matchM(Rs_D). ForwardB_D = matchM(Rt_D).
- lwstall = MemtoReg_E && Rt_E != 0 && (Rt_E == Rs_D || Rt_E == Rt_D).
- branchstall = (Branch_D && hit(Rs_D or Rt_D)) || (Jr_D && hit(Rs_D)), where hit(r) = matchE(r) || (MemtoReg_M && WriteReg_M == r && r != 0).
- mdstall = HiLoAccess_D && (MulDivBusy || MulDivStart_E).
- stall = lwstall | branchstall | mdstall.
- flush = (BranchTaken_D | J_D | Jr_D) & ~stall.
- Stall_F = stall.
- EN_FD = ~stall & ~flush. CLR_FD = flush.
- EN_DE = ~stall. CLR_DE = stall (inserts a bubble).
- All items above are combinational, with no added latency.
- Mult/div FSM, registered:
  - States IDLE and BUSY; counter cnt of CNT_W bits.
  - IDLE: on MulDivStart_E, cnt <= (MulDivOp_E ? DIV_CYCLES : MULT_CYCLES) - 1, go to BUSY.
  - BUSY: if cnt == 0, go to IDLE; else cnt <= cnt - 1.
  - MulDivBusy = (state == BUSY).
  - MulDivDone = (state == BUSY && cnt == 0).
  - Timing: start in cycle t gives Busy for cycles t+1..t+N, Done in cycle t+N, and HI/LO accessors released in cycle t+N+1.
  - MulDivStart_E while BUSY is ignored; mdstall prevents it.
- Reset (rst_n = 0 at a clk edge): state = IDLE, cnt = 0, so MulDivBusy = 0 and MulDivDone = 0. Reset aborts any operation in progress. Combinational outputs follow their inputs during reset.
- Simultaneous events:
  - A taken branch that is also stalled is not flushed this cycle; the flush occurs once the stall clears.
  - A load-use stall and a mult/div stall together give a single bubble per cycle.

Test Plan:
- WriteReg_M = 5 and WriteReg_W = 5 (both RegWrite), Rs_E = 5 -> ForwardA_E = 10. With RegWrite_M = 0 -> 01. With Rs_E = 0 -> 00.
- MemtoReg_E = 1, Rt_E = 8, Rs_D = 8 -> Stall_F = 1, EN_FD = 0, EN_DE = 0, CLR_DE = 1 for exactly one cycle, then all deasserted.
- Branch_D = 1, Rs_D = 3, RegWrite_E = 1, WriteReg_E = 3 -> one stall cycle. Next cycle BranchTaken_D = 1 -> CLR_FD = 1, EN_FD = 0, Stall_F = 0.
- MulDivStart_E = 1, MulDivOp_E = 0 at cycle 0 -> Busy in cycles 1-4, Done in cycle 4. mflo in Decode during cycles 0-4 stalls, then proceeds in cycle 5.
- div start, then rst_n = 0 in cycle 10 -> Busy = 0 in cycle 11, pending mfhi not stalled.
- Sweep all input combinations -> never EN_FD = CLR_FD = 1 and never EN_DE = CLR_DE = 1.
